// File: rtl/spi_host_pkg.sv
// Shared types and sizing helpers for the SPI mode-0 host master.
package spi_host_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        LOW,
        HIGH,
        NEXT,
        GAP
    } spi_state_t;

    localparam int unsigned BYTE_BITS = 8;

    localparam int unsigned CLK_DIV_DEF  = 4;
    localparam int unsigned CS_SETUP_DEF = 2;
    localparam int unsigned CS_GAP_DEF   = 4;

    // Width of a phase counter able to hold the longest of the three phase lengths.
    function automatic int unsigned cnt_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

    localparam int unsigned CNT_W = cnt_width(CLK_DIV_DEF, CS_SETUP_DEF, CS_GAP_DEF);

endpackage

// File: rtl/spi_sync2.sv
// Two-flop synchronizer bringing the asynchronous MISO line into the clk domain.
module spi_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops, both cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/spi_host_master.sv
// SPI mode-0 initiator (CPOL=0, CPHA=0, MSB first) with byte valid/ready in and rx pulse out.
module spi_host_master
    import spi_host_pkg::*;
#(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned CS_SETUP = 2,
    parameter int unsigned CS_GAP   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       busy,
    output logic       ss,
    output logic       sck,
    output logic       mosi,
    input  logic       miso
);

    localparam int unsigned CTR_W = cnt_width(CLK_DIV, CS_SETUP, CS_GAP);
    localparam int unsigned BIT_W = $clog2(BYTE_BITS);

    spi_state_t           state_q;
    spi_state_t           state_d;
    logic [CTR_W-1:0]     cnt_q;
    logic [CTR_W-1:0]     cnt_d;
    logic [BIT_W-1:0]     bit_q;
    logic [BIT_W-1:0]     bit_d;
    logic [BYTE_BITS-1:0] tx_sh_q;
    logic [BYTE_BITS-1:0] tx_sh_d;
    logic [BYTE_BITS-1:0] rx_sh_q;
    logic [BYTE_BITS-1:0] rx_sh_d;
    logic                 last_q;
    logic                 last_d;
    logic                 miso_s;

    logic                 hs_c;
    logic                 phase_end_c;
    logic                 byte_end_c;

    logic                 ss_d;
    logic                 sck_d;
    logic                 busy_d;
    logic                 tx_ready_d;
    logic                 rx_valid_d;
    logic [BYTE_BITS-1:0] rx_data_d;

    spi_sync2 u_miso_sync (
        .clk (clk),
        .rst (rst),
        .d   (miso),
        .q   (miso_s)
    );

    assign hs_c       = tx_valid & tx_ready;
    assign byte_end_c = (state_q == HIGH) && phase_end_c && (bit_q == BIT_W'(BYTE_BITS - 1));
    // MOSI is the MSB of the tx shift flop, so it only moves on clk edges.
    assign mosi       = tx_sh_q[BYTE_BITS-1];

    // Last cycle of the current timed phase.
    always_comb begin
        phase_end_c = 1'b0;
        case (state_q)
            SETUP:     phase_end_c = (cnt_q == CTR_W'(CS_SETUP - 1));
            LOW, HIGH: phase_end_c = (cnt_q == CTR_W'(CLK_DIV - 1));
            GAP:       phase_end_c = (cnt_q == CTR_W'(CS_GAP - 1));
            default:   phase_end_c = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (hs_c) state_d = SETUP;
            SETUP: if (phase_end_c) state_d = LOW;
            LOW:   if (phase_end_c) state_d = HIGH;
            HIGH:  if (phase_end_c) state_d = byte_end_c ? NEXT : LOW;
            NEXT: begin
                if (last_q)    state_d = GAP;
                else if (hs_c) state_d = LOW;
            end
            GAP:   if (phase_end_c) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values for the registered outputs and the datapath.
    always_comb begin
        cnt_d      = cnt_q + CTR_W'(1);
        bit_d      = bit_q;
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = rx_sh_q;
        last_d     = last_q;
        rx_data_d  = rx_data;
        rx_valid_d = 1'b0;

        if (hs_c) begin
            tx_sh_d = tx_data;
            last_d  = tx_last;
            bit_d   = '0;
        end

        // End of SCK-high: sample MISO and advance MOSI on the falling edge.
        if ((state_q == HIGH) && phase_end_c) begin
            tx_sh_d = {tx_sh_q[BYTE_BITS-2:0], 1'b0};
            rx_sh_d = {rx_sh_q[BYTE_BITS-2:0], miso_s};
            bit_d   = bit_q + 1'b1;
        end

        if (byte_end_c) begin
            rx_valid_d = 1'b1;
            rx_data_d  = {rx_sh_q[BYTE_BITS-2:0], miso_s};
        end

        if ((state_d != state_q) || (state_q == IDLE) || (state_q == NEXT)) begin
            cnt_d = '0;
        end

        ss_d       = !(state_d inside {SETUP, LOW, HIGH, NEXT});
        sck_d      = (state_d == HIGH);
        busy_d     = (state_d != IDLE);
        tx_ready_d = (state_d == IDLE) || ((state_d == NEXT) && !last_d);
    end

    // Datapath and output flops; reset aborts any frame in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            bit_q    <= '0;
            tx_sh_q  <= '0;
            rx_sh_q  <= '0;
            last_q   <= 1'b0;
            ss       <= 1'b1;
            sck      <= 1'b0;
            busy     <= 1'b0;
            tx_ready <= 1'b0;
            rx_valid <= 1'b0;
            rx_data  <= '0;
        end else begin
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            tx_sh_q  <= tx_sh_d;
            rx_sh_q  <= rx_sh_d;
            last_q   <= last_d;
            ss       <= ss_d;
            sck      <= sck_d;
            busy     <= busy_d;
            tx_ready <= tx_ready_d;
            rx_valid <= rx_valid_d;
            rx_data  <= rx_data_d;
        end
    end

endmodule

// File: tb/tb_spi_host_master.sv
// Self-checking bench for spi_host_master: directed frame scenarios with random payloads.
module tb_spi_host_master;

    localparam int CLK_DIV  = 4;
    localparam int CS_SETUP = 2;
    localparam int CS_GAP   = 4;
    // Handshake-to-rx_valid latency for a byte started from IDLE / from NEXT.
    localparam int BYTE_T   = 1 + CS_SETUP + 16 * CLK_DIV;
    localparam int NEXT_T   = 1 + 16 * CLK_DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] tx_data = 8'h00;
    logic       tx_last = 1'b0;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       busy;
    logic       ss;
    logic       sck;
    logic       mosi;
    logic       miso;

    // Simple mode-0 target: loopback, or shifts out slave_byte MSB first.
    logic       loopback = 1'b1;
    logic [7:0] slave_byte = 8'h00;
    logic [7:0] slave_sh = 8'h00;

    int tests = 0;
    int fails = 0;

    // Monitor bookkeeping (cycle stamps are negedge counts).
    int   cyc = 0;
    int   hs_t[$];
    int   ss_fall_t[$];
    int   ss_rise_t[$];
    int   busy_fall_t[$];
    int   rise_t[$];
    int   rxv_t[$];
    logic [7:0] rxd[$];
    logic mosi_bits[$];
    int   stab_err = 0;
    int   glitch_err = 0;
    int   gap_rdy_err = 0;
    logic ss_p = 1'b1;
    logic sck_p = 1'b0;
    logic busy_p = 1'b0;
    logic mosi_p = 1'b0;
    logic miso_p = 1'b0;
    int   mosi_st = 0;
    int   miso_st = 0;

    spi_host_master #(
        .CLK_DIV  (CLK_DIV),
        .CS_SETUP (CS_SETUP),
        .CS_GAP   (CS_GAP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_data  (tx_data),
        .tx_last  (tx_last),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .busy     (busy),
        .ss       (ss),
        .sck      (sck),
        .mosi     (mosi),
        .miso     (miso)
    );

    always #5 clk = ~clk;

    assign miso = loopback ? mosi : slave_sh[7];

    always @(negedge ss) slave_sh = slave_byte;
    always @(negedge sck) if (ss === 1'b0) slave_sh = {slave_sh[6:0], 1'b0};

    always @(negedge clk) begin
        cyc++;
        if (tx_valid === 1'b1 && tx_ready === 1'b1) hs_t.push_back(cyc);
        if (ss_p === 1'b1 && ss === 1'b0) ss_fall_t.push_back(cyc);
        if (ss_p === 1'b0 && ss === 1'b1) ss_rise_t.push_back(cyc);
        if (busy_p === 1'b1 && busy === 1'b0) busy_fall_t.push_back(cyc);
        if (mosi !== mosi_p) mosi_st = 1; else mosi_st++;
        if (miso !== miso_p) miso_st = 1; else miso_st++;
        if (sck === 1'b1 && sck_p === 1'b0) begin
            rise_t.push_back(cyc);
            mosi_bits.push_back(mosi);
            if (mosi_st < CLK_DIV || miso_st < CLK_DIV) stab_err++;
        end
        if (sck === 1'b1 && sck_p === 1'b1 && (mosi !== mosi_p || miso !== miso_p)) stab_err++;
        if (sck === 1'b1 && ss === 1'b1) glitch_err++;
        if (ss === 1'b1 && busy === 1'b1 && tx_ready !== 1'b0) gap_rdy_err++;
        if (rx_valid === 1'b1) begin
            rxv_t.push_back(cyc);
            rxd.push_back(rx_data);
        end
        ss_p   = ss;
        sck_p  = sck;
        busy_p = busy;
        mosi_p = mosi;
        miso_p = miso;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        hs_t.delete();
        ss_fall_t.delete();
        ss_rise_t.delete();
        busy_fall_t.delete();
        rise_t.delete();
        rxv_t.delete();
        rxd.delete();
        mosi_bits.delete();
        stab_err    = 0;
        glitch_err  = 0;
        gap_rdy_err = 0;
    endtask

    function automatic logic [7:0] bits_byte(input int base);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[7-i] = mosi_bits[base+i];
        return r;
    endfunction

    // Offer one byte and return one cycle after its handshake edge.
    task automatic offer(input logic [7:0] d, input logic l, input bit hold);
        int n;
        n = 0;
        tx_valid = 1'b1;
        tx_data  = d;
        tx_last  = l;
        while (tx_ready !== 1'b1 && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("hs_timeout", 32'(n < 1000), 32'(1));
        @(posedge clk); #1;
        if (!hold) tx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle_timeout", 32'(n < 2000), 32'(1));
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        logic [7:0] d2;
        int n;
        int base;

        // Reset values
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ss", 32'(ss), 32'(1));
        chk("rst_sck", 32'(sck), 32'(0));
        chk("rst_mosi", 32'(mosi), 32'(0));
        chk("rst_tx_ready", 32'(tx_ready), 32'(0));
        chk("rst_rx_valid", 32'(rx_valid), 32'(0));
        chk("rst_rx_data", 32'(rx_data), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_tx_ready", 32'(tx_ready), 32'(1));
        chk("idle_busy", 32'(busy), 32'(0));

        // Single-byte frames, loopback
        loopback = 1'b1;
        for (int k = 0; k < 3; k++) begin
            d = (k == 0) ? 8'hA5 : 8'($urandom);
            clear_mon();
            offer(d, 1'b1, 1'b0);
            wait_idle();
            chk("sb_rises", rise_t.size(), 8);
            chk("sb_mosi", 32'(bits_byte(0)), 32'(d));
            chk("sb_rx_count", rxv_t.size(), 1);
            chk("sb_rx_data", 32'(rxd[0]), 32'(d));
            chk("sb_ss_fall", ss_fall_t[0] - hs_t[0], 1);
            chk("sb_first_rise", rise_t[0] - hs_t[0], 1 + CS_SETUP + CLK_DIV);
            chk("sb_rx_time", rxv_t[0] - hs_t[0], BYTE_T);
            chk("sb_ss_rise", ss_rise_t[0] - rxv_t[0], 1);
            chk("sb_busy_drop", busy_fall_t[0] - ss_rise_t[0], CS_GAP);
            chk("sb_stable", stab_err, 0);
            chk("sb_glitch", glitch_err, 0);
        end

        // Target returns a byte while host sends zeros
        loopback = 1'b0;
        for (int k = 0; k < 2; k++) begin
            slave_byte = (k == 0) ? 8'h3C : 8'($urandom);
            clear_mon();
            offer(8'h00, 1'b1, 1'b0);
            wait_idle();
            chk("sl_rx_count", rxv_t.size(), 1);
            chk("sl_rx_data", 32'(rxd[0]), 32'(slave_byte));
            chk("sl_mosi", 32'(bits_byte(0)), 32'(0));
            chk("sl_stable", stab_err, 0);
        end

        // Three-byte frame with tx_valid held
        loopback = 1'b1;
        clear_mon();
        offer(8'h01, 1'b0, 1'b1);
        offer(8'h02, 1'b0, 1'b1);
        offer(8'h03, 1'b1, 1'b0);
        wait_idle();
        chk("mb_rises", rise_t.size(), 24);
        chk("mb_ss_falls", ss_fall_t.size(), 1);
        chk("mb_ss_rises", ss_rise_t.size(), 1);
        chk("mb_hs01", hs_t[1] - hs_t[0], BYTE_T);
        chk("mb_hs12", hs_t[2] - hs_t[1], NEXT_T);
        chk("mb_rx_count", rxv_t.size(), 3);
        chk("mb_rx0", 32'(rxd[0]), 32'(8'h01));
        chk("mb_rx1", 32'(rxd[1]), 32'(8'h02));
        chk("mb_rx2", 32'(rxd[2]), 32'(8'h03));
        chk("mb_rx_hs_same", rxv_t[0], hs_t[1]);
        chk("mb_mosi1", 32'(bits_byte(8)), 32'(8'h02));
        chk("mb_mosi2", 32'(bits_byte(16)), 32'(8'h03));
        chk("mb_glitch", glitch_err, 0);
        chk("mb_stable", stab_err, 0);

        // Stall in NEXT with SS held low
        clear_mon();
        d  = 8'($urandom);
        d2 = 8'($urandom);
        offer(d, 1'b0, 1'b0);
        n = 0;
        while (rxv_t.size() == 0 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        chk("st_rx_timeout", 32'(n < 500), 32'(1));
        base = 0;
        repeat (100) begin
            @(posedge clk); #1;
            if (ss !== 1'b0 || sck !== 1'b0 || tx_ready !== 1'b1) base++;
        end
        chk("st_hold", base, 0);
        offer(d2, 1'b1, 1'b0);
        wait_idle();
        chk("st_ss_falls", ss_fall_t.size(), 1);
        chk("st_resume_rise", rise_t[8] - hs_t[1], 1 + CLK_DIV);
        chk("st_rx_time", rxv_t[1] - hs_t[1], NEXT_T);
        chk("st_rx0", 32'(rxd[0]), 32'(d));
        chk("st_rx1", 32'(rxd[1]), 32'(d2));

        // Two single-byte frames back to back
        clear_mon();
        d  = 8'($urandom);
        d2 = 8'($urandom) | 8'h01;
        offer(d, 1'b1, 1'b1);
        offer(d2, 1'b1, 1'b0);
        wait_idle();
        chk("fs_ss_falls", ss_fall_t.size(), 2);
        chk("fs_ss_high", 32'((ss_fall_t[1] - ss_rise_t[0]) >= CS_GAP + 1), 32'(1));
        chk("fs_hs_gap", hs_t[1] - hs_t[0], BYTE_T + 1 + CS_GAP);
        chk("fs_gap_ready", gap_rdy_err, 0);
        chk("fs_rx1", 32'(rxd[1]), 32'(d2));

        // Reset mid-frame at the 4th SCK rise
        clear_mon();
        offer(8'($urandom), 1'b1, 1'b0);
        n = 0;
        while (rise_t.size() < 4 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        chk("mr_rise_timeout", 32'(n < 500), 32'(1));
        base = rxv_t.size();
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mr_ss", 32'(ss), 32'(1));
        chk("mr_sck", 32'(sck), 32'(0));
        chk("mr_tx_ready", 32'(tx_ready), 32'(0));
        chk("mr_busy", 32'(busy), 32'(0));
        chk("mr_rx_data", 32'(rx_data), 32'(0));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("mr_idle_ready", 32'(tx_ready), 32'(1));
        repeat (80) @(posedge clk);
        #1;
        chk("mr_no_rx", rxv_t.size(), base);
        chk("mr_ss_after", 32'(ss), 32'(1));
        chk("mr_busy_after", 32'(busy), 32'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
